// File: rtl/rr_byte_scheduler.sv
// Purpose: four-channel round-robin byte scheduler with bounded bursts feeding a registered output stage.
// Latency: one cycle from input accept to out_valid/out_data/out_ch; no combinational in_data->out_data path.
// Backpressure: when the output register is full and out_ready is low, all in_ready drop and all state holds.
//
// Ports:
//   clk        - single clock, all state on the rising edge
//   rst_n      - synchronous active-low reset
//   in_valid   - per-channel request (bit i = channel i)
//   in_ready   - per-channel accept, at most one bit high
//   in_data    - channel i byte at [DATA_W*i +: DATA_W]
//   out_valid  - output register holds a byte
//   out_ready  - downstream accept
//   out_data   - forwarded byte
//   out_ch     - source channel of out_data; drives the downstream 4:1 mux select
//
// Parameters:
//   DATA_W     - byte width per channel
//   MAX_BURST  - max consecutive beats granted to one channel (1..15)
//
// Build option:
//   SCHED_FIXED_PRIO_EN - when defined, the idle winner is the lowest-index valid
//                         channel and the round-robin pointer is not consulted.
//                         Burst limit and burst-end rules are unchanged.

module rr_byte_scheduler #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [3:0]            in_valid,
  output logic [3:0]            in_ready,
  input  logic [4*DATA_W-1:0]   in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_ch
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);
  // With a limit of one beat there is never a second beat to own, so the
  // BURST state is bypassed entirely and the pointer advances per grant.
  localparam bit MULTI_BEAT = (MAX_BURST > 1);

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  ptr;
  logic [1:0]  ptr_nxt;
  logic [1:0]  owner;
  logic [1:0]  owner_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  logic        load;
  logic        win_found;
  logic [1:0]  winner;
  logic [1:0]  grant_ch;
  logic        grant_en;
  logic        xfer;
  logic [DATA_W-1:0] sel_data;

  // The output register can take a new byte when empty or when its current
  // byte is leaving on this same edge.
  assign load = !out_valid || out_ready;

  // ---------------------------------------------------------------------------
  // Idle winner selection
  // ---------------------------------------------------------------------------
`ifdef SCHED_FIXED_PRIO_EN
  always_comb begin
    win_found = 1'b0;
    winner    = 2'd0;
    // Descending scan so the lowest valid index is the last one written.
    for (int k = 3; k >= 0; k--) begin
      if (in_valid[k]) begin
        win_found = 1'b1;
        winner    = 2'(k);
      end
    end
  end
`else
  logic [7:0] vv_rot;
  logic [3:0] rot_valid;
  logic [1:0] win_ofs;

  always_comb begin
    // Rotate the request vector so that bit 0 corresponds to channel ptr;
    // the first set bit of the rotated vector is then the offset from ptr.
    vv_rot    = {in_valid, in_valid} >> ptr;
    rot_valid = vv_rot[3:0];
    win_found = 1'b0;
    win_ofs   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (rot_valid[k]) begin
        win_found = 1'b1;
        win_ofs   = 2'(k);
      end
    end
    // 2-bit addition wraps naturally mod 4.
    winner = ptr + win_ofs;
  end
`endif

  // ---------------------------------------------------------------------------
  // Grant and handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    grant_ch = 2'd0;
    grant_en = 1'b0;
    case (state)
      S_IDLE: begin
        grant_ch = winner;
        grant_en = load && win_found;
      end
      S_BURST: begin
        // Owner is offered the slot whenever the output can load, even if it
        // has dropped valid; in that case the burst ends this cycle.
        grant_ch = owner;
        grant_en = load;
      end
      default: begin
        grant_ch = 2'd0;
        grant_en = 1'b0;
      end
    endcase
  end

  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && grant_en) begin
      in_ready = 4'b0001 << grant_ch;
    end
  end

  assign xfer = |(in_ready & in_valid);

  // Only the granted lane is muxed into the output register's D input.
  assign sel_data = in_data[DATA_W*grant_ch +: DATA_W];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (xfer) begin
          if (MULTI_BEAT) begin
            state_nxt = S_BURST;
            owner_nxt = winner;
            cnt_nxt   = 4'd1;
          end else begin
            ptr_nxt   = winner + 2'd1;
          end
        end
      end
      S_BURST: begin
        if (xfer) begin
          cnt_nxt = cnt + 4'd1;
          // Expiry hands over to IDLE with no bubble: IDLE arbitrates on the
          // very next cycle.
          if (cnt_nxt == BURST_LIM) begin
            ptr_nxt   = owner + 2'd1;
            state_nxt = S_IDLE;
          end
        end else if (load && !in_valid[owner]) begin
          // Owner went quiet while the slot was open: give up the burst. No
          // other channel is granted this cycle, which costs one bubble.
          ptr_nxt   = owner + 2'd1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      cnt       <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= 2'd0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      owner <= owner_nxt;
      cnt   <= cnt_nxt;
      if (xfer) begin
        // A concurrent out_ready means the old byte leaves on this edge as
        // the new one lands, so out_valid simply stays high.
        out_valid <= 1'b1;
        out_data  <= sel_data;
        out_ch    <= grant_ch;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_byte_scheduler.md
# rr_byte_scheduler

Four-channel, 8-bit round-robin scheduler with bounded bursts and a registered output stage. It arbitrates between four valid/ready byte sources and forwards one byte per cycle. It also presents the winning channel index, `out_ch`, which drives the 2-bit select of the decoder-based 4:1 byte mux. The block sits directly upstream of that mux/decoder stage and owns all select sequencing and flow control for it.

## Interface
- `DATA_W`, default 8: byte width per channel.
- `MAX_BURST`, default 4: maximum consecutive beats granted to one channel (legal range 1–15).

Ports:
- `clk`  in  1  — single clock; all state on rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `in_valid`  in  4  — per-channel request; bit i = channel i.
- `in_ready`  out  4  — per-channel accept; at most one bit high.
- `in_data`  in  4*DATA_W  — channel i at `[DATA_W*i +: DATA_W]`.
- `out_valid`  out  1  — output register holds a byte.
- `out_ready`  in  1  — downstream accept.
- `out_data`  out  DATA_W  — forwarded byte.
- `out_ch`  out  2  — source channel of `out_data`; drives the downstream mux select.

## Operation
- `load = !out_valid || out_ready`. When `load` = 0, everything stalls: `in_ready` = 0 and all state holds.
- Input transfer on channel i: `in_valid[i] && in_ready[i]`. On transfer, `out_data`, `out_ch` and `out_valid` = 1 load at the next edge. If `out_ready` is high with no new transfer, `out_valid` clears.
- State `ptr[1:0]` is the round-robin start point; reset value 0.
- IDLE state:
  - Winner = first channel with `in_valid` high, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - `in_ready[winner] = load`.
  - On transfer with MAX_BURST > 1: go to BURST, `owner = winner`, `cnt = 1`.
  - On transfer with MAX_BURST = 1: `ptr = winner+1`, stay in IDLE.
  - If no channel is valid, nothing changes.
- BURST state: `in_ready[owner] = load`; all other channels get 0.
  - On transfer: `cnt++`. If `cnt` reaches MAX_BURST, set `ptr = owner+1` and go to IDLE.
  - If `load` = 1 and `in_valid[owner]` = 0: set `ptr = owner+1` and go to IDLE. No grant is issued that cycle (one bubble).
- `ptr` wraps 3→0 (mod 4 arithmetic, 2 bits). `cnt` is 4 bits.
- Reset mid-burst: state returns to IDLE. A pending output byte is discarded, not delivered.
- Reset values:
  - Registered outputs: `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
  - Internal state: IDLE, `ptr` = 0, `cnt` = 0.
  - `in_ready` is forced to 0 while `rst_n` = 0.

## Timing
- Latency: an input transfer at edge N produces `out_valid` = 1 from edge N through edge N+1. Zero combinational path from `in_data` to `out_data`.
- Throughput: 1 byte/cycle while `out_ready` = 1 and requests are present.
- Burst expiry costs no bubble: IDLE arbitrates in the cycle immediately after the last beat.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and state. It has no dependency on `in_data`.
- Simultaneous `out_ready` and a new transfer: old byte leaves and new byte loads on the same edge; `out_valid` stays 1.
- Sources must hold `in_valid` and `in_data` until accepted; the block never drops an accepted byte.

## Configuration
- Macro: `SCHED_FIXED_PRIO_EN`.
- Defined: the IDLE winner is the lowest-index valid channel and `ptr` is ignored. Burst limit and burst-end rules are unchanged, so channel 0 may win again right after its own burst.
- Undefined (default): round-robin from `ptr` as described in Operation.

## Test plan
- **Single channel:** reset, then ch2 presents 0xA5, 0x5A with `out_ready` = 1. Expected: `out_data` = 0xA5 then 0x5A with `out_ch` = 2, each one cycle after accept.
- **Round-robin:**
  - Stimulus: MAX_BURST = 1, all four channels valid continuously, `out_ready` = 1.
  - Expected: `out_ch` sequence 0,1,2,3,0,1, with no idle cycles.
- **Burst limit:**
  - Stimulus: MAX_BURST = 4, ch1 and ch3 always valid.
  - Expected: `out_ch` sequence 1,1,1,1,3,3,3,3,1, with no bubble at the switch.
- **Early burst end:** ch0 sends 2 beats, then drops `in_valid`; ch2 is valid. Expected: one bubble cycle, then ch2 is granted; `ptr` = 1 at the switch.
- **Backpressure:**
  - Stimulus: `out_ready` = 0 for 3 cycles while `out_valid` = 1.
  - Expected: `in_ready` = 0 and `out_data`/`out_ch` stable for those cycles. With `out_ready` = 1 and a concurrent transfer, the old byte leaves and the new byte loads on the same edge.
- **Reset mid-burst:**
  - Stimulus: assert `rst_n` = 0 for one cycle during a ch3 burst with `out_valid` = 1.
  - Expected: `out_valid` = 0, `out_ch` = 0, `in_ready` = 0. The next grant follows `ptr` = 0 (ch0 first if valid).
  - With `SCHED_FIXED_PRIO_EN` defined: ch0 wins whenever valid in IDLE.
